// File: rtl/ct_spsram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ct_spsram_ctrl_pkg
// Shared definitions for the 256x52 single-port SRAM requester controller:
// controller state encoding, default geometry and the SRAM pin values that
// mean "no access" (all SRAM control pins are active low).
// ---------------------------------------------------------------------------
package ct_spsram_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 52;
  localparam int DEF_RSP_DEPTH  = 3;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Idle SRAM pin levels: chip disabled, no global write, every bit masked.
  localparam logic SRAM_CEN_IDLE     = 1'b1;
  localparam logic SRAM_GWEN_IDLE    = 1'b1;
  localparam logic SRAM_WEN_IDLE_BIT = 1'b1;

endpackage

// File: rtl/ct_spsram_256x52_ctrl_if.sv
// ---------------------------------------------------------------------------
// ct_spsram_256x52_ctrl_if
// Client-side bus of the SRAM controller.
//   req_*  : request stream (valid/ready), read or bit-masked write
//   rsp_*  : read response stream (valid/ready), data is the FIFO head
// Modports: master = client (cache/tag logic), slave = controller.
// ---------------------------------------------------------------------------
interface ct_spsram_256x52_ctrl_if
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] req_wmask;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rdata
  );

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rdata
  );

endinterface

// File: rtl/ct_spsram_ctrl_rsp_fifo.sv
// ---------------------------------------------------------------------------
// ct_spsram_ctrl_rsp_fifo
// Small ordered FIFO holding read responses.
// Ports:
//   CLK, RST : clock, asynchronous active-high reset (entries clear to 0)
//   push/din : write din at the tail (ignored when full)
//   pop      : drop the head entry (ignored when empty)
//   dout     : head entry, 0 when empty
//   cnt      : number of stored entries
//   empty    : cnt == 0
// Push and pop in the same cycle leave cnt unchanged.
// ---------------------------------------------------------------------------
module ct_spsram_ctrl_rsp_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 52
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0]     cnt,
  output logic                           empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (cnt_reg == '0);
  assign do_push = push && (cnt_reg != CW'(DEPTH));
  assign do_pop  = pop && !empty;

  // One register per entry so each storage word resets to zero.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_reg;
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        entry_reg <= '0;
      end else if (do_push && (wr_ptr_reg == PW'(gi))) begin
        entry_reg <= din;
      end
    end
    assign mem_q[gi] = entry_reg;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
      end
      if (do_push && !do_pop) begin
        cnt_reg <= cnt_reg + CW'(1);
      end else if (do_pop && !do_push) begin
        cnt_reg <= cnt_reg - CW'(1);
      end
    end
  end

  assign dout = empty ? '0 : mem_q[rd_ptr_reg];
  assign cnt  = cnt_reg;

endmodule

// File: rtl/ct_spsram_256x52_ctrl.sv
// ---------------------------------------------------------------------------
// ct_spsram_256x52_ctrl
// Requester-side controller for the 256x52 single-port SRAM macro.
// After reset it optionally zero-fills the array (one write per cycle), then
// turns client requests into SRAM cycles. Read data arrives on sram_q one
// cycle after the access and is queued in a response FIFO; a request is only
// accepted when a FIFO slot is guaranteed for it (credit check).
// Ports:
//   CLK, RST   : clock, asynchronous active-high reset
//   bus        : client request/response interface (slave side)
//   init_done  : high from the first RUN cycle until reset
//   sram_a/cen/gwen/wen/d : SRAM pins (controls active low)
//   sram_q     : SRAM read data, valid the cycle after a read access
// ---------------------------------------------------------------------------
module ct_spsram_256x52_ctrl
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH,
  parameter int INIT_EN    = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  ct_spsram_256x52_ctrl_if.slave  bus,
  output logic                    init_done,
  output logic [ADDR_WIDTH-1:0]   sram_a,
  output logic                    sram_cen,
  output logic                    sram_gwen,
  output logic [DATA_WIDTH-1:0]   sram_wen,
  output logic [DATA_WIDTH-1:0]   sram_d,
  input  logic [DATA_WIDTH-1:0]   sram_q
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH - 1);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH:0]   cnt_reg, cnt_next;
  logic                  init_done_reg;
  logic                  rd_pend_reg, rd_pend_next;
  logic [CW-1:0]         fifo_cnt;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  credit_ok;
  logic                  accept;
  logic                  fifo_pop;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= ST_BOOT;
      cnt_reg       <= '0;
      init_done_reg <= 1'b0;
      rd_pend_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      init_done_reg <= (state_next == ST_RUN);
      rd_pend_reg   <= rd_pend_next;
    end
  end

  // Reads in flight (pending on sram_q) plus stored responses must leave a
  // free slot, so the FIFO can never overflow even with rsp_rdy held low.
  assign credit_ok   = ({1'b0, fifo_cnt} + {{CW{1'b0}}, rd_pend_reg}) < (CW + 1)'(RSP_DEPTH);
  assign bus.req_rdy = (state_reg == ST_RUN) && credit_ok;
  assign accept      = bus.req_vld && bus.req_rdy;
  assign fifo_pop    = bus.rsp_rdy && !fifo_empty;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    rd_pend_next = 1'b0;
    sram_cen     = SRAM_CEN_IDLE;
    sram_gwen    = SRAM_GWEN_IDLE;
    sram_wen     = {DATA_WIDTH{SRAM_WEN_IDLE_BIT}};
    sram_a       = '0;
    sram_d       = '0;
    case (state_reg)
      ST_BOOT: begin
        cnt_next   = '0;
        state_next = (INIT_EN != 0) ? ST_INIT : ST_RUN;
      end
      ST_INIT: begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = cnt_reg[ADDR_WIDTH-1:0];
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          state_next = ST_RUN;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_RUN: begin
        if (accept) begin
          sram_cen = 1'b0;
          sram_a   = bus.req_addr;
          if (bus.req_wr) begin
            sram_gwen = 1'b0;
            sram_wen  = ~bus.req_wmask;
            sram_d    = bus.req_wdata;
          end else begin
            rd_pend_next = 1'b1;
          end
        end
      end
      default: state_next = ST_BOOT;
    endcase
  end

  // sram_q carries the read data in the cycle after the access, which is
  // exactly when rd_pend_reg is set.
  ct_spsram_ctrl_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (rd_pend_reg),
    .pop   (fifo_pop),
    .din   (sram_q),
    .dout  (fifo_dout),
    .cnt   (fifo_cnt),
    .empty (fifo_empty)
  );

  assign bus.rsp_vld   = !fifo_empty;
  assign bus.rsp_rdata = fifo_dout;
  assign init_done     = init_done_reg;

endmodule

// File: tb/tb_ct_spsram_256x52_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ct_spsram_256x52_ctrl
// Drives the controller against a behavioural SRAM macro and compares every
// cycle with a reference model built from the controller's rules: the
// array contents as an array, outstanding reads as a queue of (data, cycle
// the response becomes visible), and the credit rule "accept while fewer
// than RSP_DEPTH reads are unreturned".
// ---------------------------------------------------------------------------
module tb_ct_spsram_256x52_ctrl;

  localparam int AW      = 8;
  localparam int DW      = 52;
  localparam int DEPTH   = 3;
  localparam int RUN_CYC = 258;  // cycle 1 = BOOT, 2..257 = INIT

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          init_done;
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  ct_spsram_256x52_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ct_spsram_256x52_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RSP_DEPTH  (DEPTH),
    .INIT_EN    (1)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .init_done (init_done),
    .sram_a    (sram_a),
    .sram_cen  (sram_cen),
    .sram_gwen (sram_gwen),
    .sram_wen  (sram_wen),
    .sram_d    (sram_d),
    .sram_q    (sram_q)
  );

  always #5 CLK = ~CLK;

  // SRAM macro: write-then-read, Q valid the cycle after a read; Q shows
  // junk after any other cycle so a mistimed sample is visible.
  logic [DW-1:0] sram_mem [256];
  always @(posedge CLK) begin
    if (!sram_cen && sram_gwen) begin
      sram_q <= sram_mem[sram_a];
    end else begin
      sram_q <= DW'({$urandom(), $urandom()});
      if (!sram_cen) begin
        for (int i = 0; i < DW; i++) begin
          if (!sram_wen[i]) sram_mem[sram_a][i] <= sram_d[i];
        end
      end
    end
  end

  // Reference model
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  logic [DW-1:0] ref_mem [256];
  rsp_t          exp_q [$];
  int            cyc;
  int            checks;
  int            errors;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom(), $urandom()});
  endfunction

  task automatic drive(input bit vld, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] m);
    bus.req_vld   = vld;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wmask = m;
  endtask

  // One clock cycle: compare at the falling edge, update the model, then
  // return 1 time unit after the next rising edge so the caller can drive.
  task automatic cycle();
    bit            run, in_init, exp_rdy, exp_vld, acc;
    logic          e_cen, e_gwen;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_wen, e_d, e_rdata;
    rsp_t          r;
    @(negedge CLK);
    if (RST) begin
      run = 0; in_init = 0;
      exp_q.delete();
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;  // init will zero the array
    end else begin
      run     = (cyc >= RUN_CYC);
      in_init = (cyc >= 2) && (cyc < RUN_CYC);
    end
    exp_rdy = run && (exp_q.size() < DEPTH);
    exp_vld = !RST && (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    e_rdata = exp_vld ? exp_q[0].data : '0;
    acc     = bus.req_vld && exp_rdy;
    e_cen = 1'b1; e_gwen = 1'b1; e_wen = '1; e_a = '0; e_d = '0;
    if (in_init) begin
      e_cen = 1'b0; e_gwen = 1'b0; e_wen = '0; e_a = AW'(cyc - 2);
    end else if (acc) begin
      e_cen = 1'b0;
      e_a   = bus.req_addr;
      if (bus.req_wr) begin
        e_gwen = 1'b0; e_wen = ~bus.req_wmask; e_d = bus.req_wdata;
      end
    end
    chk("init_done", 64'(init_done), 64'(run));
    chk("req_rdy", 64'(bus.req_rdy), 64'(exp_rdy));
    chk("rsp_vld", 64'(bus.rsp_vld), 64'(exp_vld));
    chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e_rdata));
    chk("sram_cen", 64'(sram_cen), 64'(e_cen));
    chk("sram_gwen", 64'(sram_gwen), 64'(e_gwen));
    chk("sram_wen", 64'(sram_wen), 64'(e_wen));
    chk("sram_a", 64'(sram_a), 64'(e_a));
    chk("sram_d", 64'(sram_d), 64'(e_d));
    if (exp_vld && bus.rsp_rdy) void'(exp_q.pop_front());
    if (acc) begin
      if (bus.req_wr) begin
        ref_mem[bus.req_addr] = (ref_mem[bus.req_addr] & ~bus.req_wmask)
                              | (bus.req_wdata & bus.req_wmask);
      end else begin
        r.data = ref_mem[bus.req_addr];
        r.due  = cyc + 2;
        exp_q.push_back(r);
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic release_rst();
    RST = 1'b0;
    cyc = 1;
  endtask

  task automatic run_until(input int c);
    while (cyc < c) begin
      cycle();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.rsp_rdy = 1'b1;
    drive(0, 0, '0, '0, '0);
    while (exp_q.size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    for (int i = 0; i < 256; i++) sram_mem[i] = DW'({$urandom(), $urandom()});
    drive(0, 0, '0, '0, '0);
    bus.rsp_rdy = 1'b0;

    // 1: reset, then init sweep with requests offered but refused
    repeat (3) cycle();
    release_rst();
    while (cyc < RUN_CYC - 3) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            AW'($urandom), rnd_data(), rnd_data());
      bus.rsp_rdy = $urandom_range(0, 1) == 1;
      cycle();
    end
    drive(0, 0, '0, '0, '0);
    bus.rsp_rdy = 1'b1;
    run_until(RUN_CYC + 2);

    // 2: full write then read back, read of untouched address
    drive(1, 1, 8'h10, 52'hA_BCDE_F012_3456, '1); cycle();
    drive(1, 0, 8'h10, '0, '0);                   cycle();
    drive(1, 0, 8'h11, '0, '0);                   cycle();
    drive(0, 0, '0, '0, '0);
    repeat (4) cycle();

    // 3: partial write
    drive(1, 1, 8'h20, '1, 52'h0_0000_0000_00FF); cycle();
    drive(0, 0, '0, '0, '0);                      cycle();
    drive(1, 0, 8'h20, '0, '0);                   cycle();
    drive(0, 0, '0, '0, '0);
    repeat (4) cycle();

    // 4: back-to-back reads with rsp_rdy high
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, AW'(i), rnd_data(), '1);
      cycle();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, AW'(i), '0, '0);
      cycle();
    end
    drive(0, 0, '0, '0, '0);
    repeat (4) cycle();

    // 5: responses stalled, credits exhausted, then drained
    bus.rsp_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, AW'(i), '0, '0);
      cycle();
    end
    drive(0, 0, '0, '0, '0);
    repeat (2) cycle();
    drain();
    repeat (2) cycle();

    // Random traffic on a small address window for read-after-write hits
    for (int i = 0; i < 1500; i++) begin
      logic [DW-1:0] m;
      case ($urandom_range(0, 3))
        0:       m = '0;
        1:       m = '1;
        default: m = rnd_data();
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            AW'($urandom_range(0, 15)), rnd_data(), m);
      bus.rsp_rdy = $urandom_range(0, 3) != 0;
      cycle();
    end
    drain();

    // 6a: reset in the middle of init (address 100), init restarts at 0
    RST = 1'b1;
    repeat (2) cycle();
    release_rst();
    run_until(102);
    RST = 1'b1;
    repeat (2) cycle();
    release_rst();
    run_until(RUN_CYC + 2);

    // 6b: reset with two reads outstanding
    bus.rsp_rdy = 1'b0;
    drive(1, 1, 8'h30, rnd_data(), '1); cycle();
    drive(1, 0, 8'h30, '0, '0);         cycle();
    drive(1, 0, 8'h31, '0, '0);         cycle();
    drive(0, 0, '0, '0, '0);
    RST = 1'b1;
    repeat (2) cycle();
    release_rst();
    bus.rsp_rdy = 1'b1;
    run_until(RUN_CYC + 1);
    drive(1, 0, 8'h30, '0, '0); cycle();
    drive(1, 0, 8'h10, '0, '0); cycle();
    drive(0, 0, '0, '0, '0);
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ct_spsram_256x52_ctrl.md
Name: ct_spsram_256x52_ctrl

Overview:
Requester-side controller for the 256x52 single-port SRAM macro, i.e. the initiator that drives the SRAM's A/CEN/GWEN/WEN/D pins and consumes Q.
- Converts a valid/ready request stream (read, or bit-masked write) into SRAM cycles.
- Zero-initialises the array after reset.
- Returns read data through a credit-protected response FIFO with valid/ready handshake.
- Sits between a pipeline client (cache/tag logic) and ct_spsram_256x52.

Parameters:
ADDR_WIDTH, 8, SRAM address width (256 entries)
DATA_WIDTH, 52, data and bit-write-enable width
RSP_DEPTH, 3, response FIFO entries; 3 gives full read throughput
INIT_EN, 1, 1 = zero-fill the array after reset; 0 = skip init

Ports:
CLK  in  1  single clock, rising edge
RST  in  1  asynchronous, active-high reset
req_vld  in  1  request valid
req_rdy  out  1  request ready
req_wr  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  write data
req_wmask  in  DATA_WIDTH  active-high per-bit write mask
rsp_vld  out  1  read response valid
rsp_rdy  in  1  read response ready
rsp_rdata  out  DATA_WIDTH  read data (FIFO head)
init_done  out  1  high once array is initialised and requests are accepted
sram_a  out  ADDR_WIDTH  to SRAM A
sram_cen  out  1  to SRAM CEN, active low
sram_gwen  out  1  to SRAM GWEN, active low global write
sram_wen  out  DATA_WIDTH  to SRAM WEN, active-low per bit
sram_d  out  DATA_WIDTH  to SRAM D
sram_q  in  DATA_WIDTH  from SRAM Q, valid the cycle after a read access

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high and clears all state.
- State machine: BOOT -> INIT -> RUN.
  - BOOT lasts exactly 1 cycle.
  - BOOT -> INIT when INIT_EN=1; BOOT -> RUN when INIT_EN=0.
- Reset and idle output values (also held during BOOT):
  - req_rdy=0, rsp_vld=0, rsp_rdata=0, init_done=0.
  - sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
- INIT state:
  - Counter runs 0..255, one write per cycle.
  - Each write drives cen=0, gwen=0, wen=all 0, d=0, a=counter.
  - After address 255, next state is RUN.
  - init_done is registered: it goes high in the first RUN cycle and stays high until RST.
  - INIT length with INIT_EN=1: 256 cycles. init_done rises 258 cycles after RST deassertion edge (BOOT + 256 + 1).
- RUN state, request acceptance:
  - req_rdy = (fifo_cnt + rd_pend) < RSP_DEPTH.
  - req_rdy does not depend on req_vld or req_wr.
  - Accept = req_vld & req_rdy. SRAM pins are driven combinationally in the accept cycle N: cen=0, a=req_addr.
- RUN state, write:
  - gwen=0, wen=~req_wmask, d=req_wdata.
  - A write with wmask=0 is still issued and leaves the array unchanged.
  - No response is generated.
- RUN state, read:
  - gwen=1, wen=all 1, d=0.
  - rd_pend is set at the end of cycle N.
  - sram_q is sampled at the end of cycle N+1 and pushed into the FIFO.
  - rsp_vld is high from cycle N+2 (load-to-use latency 2).
  - rd_pend is cleared at the end of N+1 unless a new read is accepted in N+1.
- RUN state, no accept: SRAM pins return to idle values.
- Response FIFO:
  - Ordered.
  - Push and pop in the same cycle are allowed and leave the count unchanged.
  - rsp_rdata = head entry, or 0 when empty.
  - rsp_vld and rsp_rdata stay stable while rsp_rdy=0.
- Overflow is impossible by construction (credit check). Verification asserts fifo_cnt <= RSP_DEPTH.
- Back-to-back reads: with rsp_rdy held high and RSP_DEPTH=3, one read is accepted every cycle.
- Read after write to the same address in consecutive cycles returns the new data. The SRAM is write-then-read; no bypass is required.
- Reset mid-operation, any state:
  - Pending reads and FIFO contents are discarded.
  - init_done drops.
  - The FSM returns to BOOT and init restarts at address 0.
- Address width arithmetic: the init counter is ADDR_WIDTH+1 bits; the terminal condition is counter == 2**ADDR_WIDTH-1.

Decomposition:
- Package ct_spsram_ctrl_pkg holds:
  - state encodings BOOT/INIT/RUN (2-bit);
  - default ADDR_WIDTH/DATA_WIDTH/RSP_DEPTH;
  - SRAM idle pin constants.
- One sub-module: ct_spsram_ctrl_rsp_fifo, a synchronous FIFO with parameters DEPTH and WIDTH.
  - Ports: push, pop, din, dout, cnt, empty.
  - RST is asynchronous and active-high; entries reset to 0.

Test Plan:
1. Reset release with INIT_EN=1 -> cen=0/gwen=0 for exactly 256 cycles, a=0..255, d=0; init_done=1 at cycle 258; req_rdy=0 before that.
2. Write addr 0x10, data 0xA_BCDE_F012_3456, mask all 1, then read 0x10 -> rsp_vld two cycles after the read accept, rsp_rdata=0xA_BCDE_F012_3456. Read of an untouched address 0x11 -> 0.
3. Partial write to 0x20 (previously 0x0) with data all 1 and mask=0x0_0000_0000_00FF -> sram_wen=0xF_FFFF_FFFF_FF00; a later read of 0x20 returns 0x0_0000_0000_00FF.
4. Reads 0..7 back-to-back with rsp_rdy=1 -> req_rdy stays 1, responses return in order one per cycle, data matches previous writes.
5. Reads with rsp_rdy=0 -> exactly 3 reads are accepted, then req_rdy=0. Raising rsp_rdy drains the 3 responses in order and req_rdy returns to 1.
6. Assert RST during INIT at address 100, and separately with 2 reads pending -> rsp_vld=0, FIFO empty, and init restarts at a=0 after release.
